// File: rtl/aes_inv_cipher_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_ctrl_if
// Description : Handshake, round-key and result bundle for the iterative
//               AES-128 inverse-cipher sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    // Environment side: block source, key store and result sink
    modport master (
        output in_valid,
        output ciphertext,
        output rk_data,
        output out_ready,
        input  in_ready,
        input  rk_idx,
        input  out_valid,
        input  plaintext,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        input  ciphertext,
        input  rk_data,
        input  out_ready,
        output in_ready,
        output rk_idx,
        output out_valid,
        output plaintext,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_ctrl
// Description : Iterative AES-128 decryption sequencer. One inverse round per
//               clock; round keys are fetched combinationally from an
//               external expanded-key store addressed by rk_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    aes_inv_cipher_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] c_LAST_KEY   = 4'd10;
    localparam logic [3:0] c_FIRST_RND  = 4'd9;
    localparam logic [3:0] c_FINAL_KEY  = 4'd0;

    // Inverse S-box, entry 0x00 in the top byte
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // ------------------------------------------------------------------------
    // Combinational round primitives (byte 0 = [127:120], column-major)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_inv_sbox[2047 - 8 * int'(b) -: 8];
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4]
    function automatic logic [127:0] aes_inv_shiftrows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] =
                    s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] aes_inv_subbytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return r;
    endfunction

    // GF(2^8) multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column matrix [0e 0b 0d 09] rotated per row
    function automatic logic [127:0] aes_inv_mixcolumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a  [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2;
        logic [7:0]   x4;
        logic [7:0]   x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                a[k]  = s[127 - 8 * (4 * c + k) -: 8];
                x2    = xt(a[k]);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[k] = x8 ^ a[k];
                mb[k] = x8 ^ x2 ^ a[k];
                md[k] = x8 ^ x4 ^ a[k];
                me[k] = x8 ^ x4 ^ x2;
            end
            r[127 - 8 * (4 * c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[127 - 8 * (4 * c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[127 - 8 * (4 * c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[127 - 8 * (4 * c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]   fsm_q;
    logic [1:0]   fsm_d;
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic [127:0] pt_q;
    logic [127:0] pt_d;
    logic [3:0]   round_cnt_q;
    logic [3:0]   round_cnt_d;

    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic [3:0]   w_rk_idx;

    // Shared round datapath; FINAL taps it before InvMixColumns
    assign w_isr = aes_inv_shiftrows(data_q);
    assign w_isb = aes_inv_subbytes(w_isr);
    assign w_ark = w_isb ^ bus.rk_data;
    assign w_imc = aes_inv_mixcolumns(w_ark);

    // State register: all flops, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            data_q      <= '0;
            pt_q        <= '0;
            round_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            pt_q        <= pt_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Next-state logic; round_cnt of 1 (or a corrupt 0) ends the ROUND phase
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (bus.in_valid)        fsm_d = S_ROUND;
            S_ROUND: if (round_cnt_q <= 4'd1) fsm_d = S_FINAL;
            S_FINAL:                          fsm_d = S_DONE;
            S_DONE:  if (bus.out_ready)       fsm_d = S_IDLE;
            default:                          fsm_d = S_IDLE;
        endcase
    end

    // Output decode and datapath updates per state
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_rk_idx    = c_FINAL_KEY;
        data_d      = data_q;
        pt_d        = pt_q;
        round_cnt_d = round_cnt_q;
        case (fsm_q)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                w_rk_idx   = c_LAST_KEY;
                if (bus.in_valid) begin
                    data_d      = bus.ciphertext ^ bus.rk_data;
                    round_cnt_d = c_FIRST_RND;
                end
            end
            S_ROUND: begin
                w_rk_idx = round_cnt_q;
                data_d   = w_imc;
                if (round_cnt_q != 4'd0) begin
                    round_cnt_d = round_cnt_q - 4'd1;
                end
            end
            S_FINAL: begin
                w_rk_idx = c_FINAL_KEY;
                pt_d     = w_ark;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_rk_idx    = c_FINAL_KEY;
            end
            default: begin
                w_busy   = 1'b0;
                w_rk_idx = c_LAST_KEY;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.rk_idx    = w_rk_idx;
    assign bus.plaintext = pt_q;

endmodule
`default_nettype wire
